// File: rtl/video_dram_pkg.sv
// Shared constants and FSM state type for the video reverb DRAM frame-store scheduler.
package video_dram_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE_RD = 2'd1,
      ISSUE_WR = 2'd2,
      PAUSED   = 2'd3
   } state_t;

   localparam int unsigned WORD_BYTES     = 16;
   localparam int unsigned VD_FRAME_WORDS = 115200;
   localparam logic [26:0] VD_BUF0_BASE   = 27'h0000000;
   localparam logic [26:0] VD_BUF1_BASE   = 27'h0200000;
endpackage

// File: rtl/video_dram_arb_pick.sv
// Write/read arbitration: writes win when starved or urgent, otherwise reads win.
module video_dram_arb_pick
   import video_dram_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned WR_URGENT    = 48
) (
   input  logic       wr_elig,
   input  logic       rd_elig,
   input  logic [3:0] starve_cnt,
   input  logic [7:0] wr_avail,
   output logic       grant_valid,
   output logic       grant_write
);
   always_comb begin
      grant_valid = wr_elig | rd_elig;
      grant_write = wr_elig && (!rd_elig ||
                                32'(starve_cnt) >= STARVE_LIMIT ||
                                32'(wr_avail) >= WR_URGENT);
   end
endmodule

// File: rtl/video_dram_scheduler.sv
// Shares one DRAM command port between the reverb write stream and the read prefetch,
// ping-ponging two frame buffers on frame_sync.
module video_dram_scheduler
   import video_dram_pkg::*;
#(
   parameter int unsigned       ADDR_W       = 27,
   parameter int unsigned       BURST_BEATS  = 8,
   parameter int unsigned       FRAME_WORDS  = VD_FRAME_WORDS,
   parameter logic [ADDR_W-1:0] BUF0_BASE    = ADDR_W'(VD_BUF0_BASE),
   parameter logic [ADDR_W-1:0] BUF1_BASE    = ADDR_W'(VD_BUF1_BASE),
   parameter int unsigned       STARVE_LIMIT = 4,
   parameter int unsigned       WR_URGENT    = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              frame_sync,
   input  logic [7:0]        wr_avail,
   input  logic [7:0]        rd_space,
   input  logic              rd_beat_valid,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic              buf_sel,
   output logic              busy,
   output logic              sync_err
);
   localparam logic [16:0] IDX_BURST   = 17'(BURST_BEATS);
   localparam logic [16:0] IDX_FRAME   = 17'(FRAME_WORDS);
   localparam logic [8:0]  OUT_BURST   = 9'(BURST_BEATS);
   localparam logic [7:0]  AVAIL_BURST = 8'(BURST_BEATS);

   state_t      state;
   logic [16:0] wr_idx, rd_idx, eff_wr, eff_rd;
   logic [8:0]  rd_out, rd_free;
   logic [3:0]  starve_cnt, eff_starve;
   logic        pending_sync, issuing, apply, eff_buf, rd_hs;
   logic        wr_elig, rd_elig, grant_valid, grant_write;
   logic [ADDR_W-1:0] wr_addr, rd_addr;

   // A pending swap is applied in the same cycle the next command is chosen, so the
   // decision already sees the new buffer and cleared indices.
   always_comb begin
      issuing    = (state == ISSUE_RD) || (state == ISSUE_WR);
      apply      = !issuing && (pending_sync || frame_sync);
      rd_hs      = cmd_valid && cmd_ready && (state == ISSUE_RD);
      eff_buf    = apply ? ~buf_sel : buf_sel;
      eff_wr     = apply ? '0 : wr_idx;
      eff_rd     = apply ? '0 : rd_idx;
      eff_starve = apply ? '0 : starve_cnt;
      rd_free    = {1'b0, rd_space} - rd_out;
      wr_elig    = (wr_avail >= AVAIL_BURST) && (eff_wr < IDX_FRAME);
      rd_elig    = ({1'b0, rd_space} >= rd_out) && (rd_free >= OUT_BURST) &&
                   (eff_rd < IDX_FRAME);
      wr_addr    = (eff_buf ? BUF1_BASE : BUF0_BASE) + ADDR_W'(eff_wr) * ADDR_W'(WORD_BYTES);
      rd_addr    = (eff_buf ? BUF0_BASE : BUF1_BASE) + ADDR_W'(eff_rd) * ADDR_W'(WORD_BYTES);
   end

   video_dram_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .WR_URGENT    (WR_URGENT)
   ) u_arb (
      .wr_elig     (wr_elig),
      .rd_elig     (rd_elig),
      .starve_cnt  (eff_starve),
      .wr_avail    (wr_avail),
      .grant_valid (grant_valid),
      .grant_write (grant_write)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cmd_valid    <= 1'b0;
         cmd_write    <= 1'b0;
         cmd_addr     <= '0;
         buf_sel      <= 1'b0;
         sync_err     <= 1'b0;
         wr_idx       <= '0;
         rd_idx       <= '0;
         rd_out       <= '0;
         starve_cnt   <= '0;
         pending_sync <= 1'b0;
      end else begin
         pending_sync <= issuing && (pending_sync || frame_sync);
         rd_out <= rd_out + (rd_hs ? OUT_BURST : 9'd0) - (rd_beat_valid ? 9'd1 : 9'd0);
         if (apply) begin
            buf_sel    <= ~buf_sel;
            sync_err   <= sync_err | (wr_idx != IDX_FRAME);
            wr_idx     <= '0;
            rd_idx     <= '0;
            starve_cnt <= '0;
         end
         case (state)
            IDLE: begin
               if (!enable) begin
                  state <= PAUSED;
               end else if (grant_valid) begin
                  state     <= grant_write ? ISSUE_WR : ISSUE_RD;
                  cmd_valid <= 1'b1;
                  cmd_write <= grant_write;
                  cmd_addr  <= grant_write ? wr_addr : rd_addr;
                  if (grant_write)
                     starve_cnt <= '0;
                  else if (wr_elig)
                     starve_cnt <= (eff_starve == '1) ? eff_starve : eff_starve + 4'd1;
               end
            end
            ISSUE_RD: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  rd_idx    <= rd_idx + IDX_BURST;
                  state     <= IDLE;
               end
            end
            ISSUE_WR: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  wr_idx    <= wr_idx + IDX_BURST;
                  state     <= IDLE;
               end
            end
            PAUSED: begin
               if (enable)
                  state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_video_dram_scheduler.sv
// Directed bench for video_dram_scheduler with a cycle-level reference model.
module tb_video_dram_scheduler;
   localparam int unsigned FW = 128;
   localparam int unsigned BB = 8;
   localparam logic [26:0] B1 = 27'h0200000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        frame_sync = 1'b0;
   logic [7:0]  wr_avail = '0;
   logic [7:0]  rd_space = '0;
   logic        rd_beat_valid = 1'b0;
   logic        cmd_valid, cmd_ready = 1'b1, cmd_write, buf_sel, busy, sync_err;
   logic [26:0] cmd_addr;

   int total = 0;
   int bad = 0;
   bit chk_on = 0;

   video_dram_scheduler #(
      .ADDR_W       (27),
      .BURST_BEATS  (BB),
      .FRAME_WORDS  (FW),
      .BUF0_BASE    (27'h0),
      .BUF1_BASE    (B1),
      .STARVE_LIMIT (4),
      .WR_URGENT    (48)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .frame_sync    (frame_sync),
      .wr_avail      (wr_avail),
      .rd_space      (rd_space),
      .rd_beat_valid (rd_beat_valid),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .buf_sel       (buf_sel),
      .busy          (busy),
      .sync_err      (sync_err)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: m_mode 0 = waiting for work, 1 = command offered, 2 = paused.
   int          m_mode, m_wr, m_rd, m_out, m_starve;
   bit          m_write, m_buf, m_pend, m_err, m_we, m_re;
   logic [26:0] m_addr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_wr = 0; m_rd = 0; m_out = 0; m_starve = 0;
         m_write = 0; m_buf = 0; m_pend = 0; m_err = 0; m_addr = '0;
      end else begin
         if (m_mode == 1) begin
            if (frame_sync) m_pend = 1;
            if (cmd_ready) begin
               if (m_write) m_wr += BB;
               else begin
                  m_rd += BB;
                  m_out += BB;
               end
               m_mode = 0;
            end
         end else begin
            if (m_pend || frame_sync) begin
               if (m_wr != FW) m_err = 1;
               m_buf = !m_buf;
               m_wr = 0; m_rd = 0; m_starve = 0; m_pend = 0;
            end
            if (m_mode == 2) begin
               if (enable) m_mode = 0;
            end else if (!enable) begin
               m_mode = 2;
            end else begin
               m_we = int'(wr_avail) >= BB && m_wr < FW;
               m_re = int'(rd_space) >= m_out + BB && m_rd < FW;
               if (m_we && (!m_re || m_starve >= 4 || int'(wr_avail) >= 48)) begin
                  m_mode = 1; m_write = 1; m_starve = 0;
                  m_addr = (m_buf ? B1 : 27'h0) + 27'(m_wr * 16);
               end else if (m_re) begin
                  if (m_we) m_starve++;
                  m_mode = 1; m_write = 0;
                  m_addr = (m_buf ? 27'h0 : B1) + 27'(m_rd * 16);
               end
            end
         end
         if (rd_beat_valid) m_out -= 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         chk("cmd_valid", 32'(cmd_valid), 32'(m_mode == 1));
         if (m_mode == 1) begin
            chk("cmd_write", 32'(cmd_write), 32'(m_write));
            chk("cmd_addr", 32'(cmd_addr), 32'(m_addr));
         end
         chk("buf_sel", 32'(buf_sel), 32'(m_buf));
         chk("busy", 32'(busy), 32'(m_mode != 0));
         chk("sync_err", 32'(sync_err), 32'(m_err));
      end
   end

   bit          log_w[$];
   logic [26:0] log_a[$];
   always @(posedge clk) begin
      if (rst_n && cmd_valid && cmd_ready) begin
         log_w.push_back(cmd_write);
         log_a.push_back(cmd_addr);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_hs(input int n, input int budget, input string name);
      int i = 0;
      while (log_w.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(name, 32'(log_w.size() >= n), 32'd1);
   endtask

   task automatic pulse_sync();
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && m_out > 0; i++) begin
         rd_beat_valid = 1'b1;
         @(negedge clk);
      end
      rd_beat_valid = 1'b0;
   endtask

   int exp_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   logic [26:0] held;

   initial begin
      cycles(2);
      chk("rst_cmd_valid", 32'(cmd_valid), 0);
      chk("rst_buf_sel", 32'(buf_sel), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cmd_addr", 32'(cmd_addr), 0);
      rst_n = 1'b1;
      chk_on = 1;

      // Writes only, run to the end of the (shortened) frame.
      wr_avail = 8'd8;
      cycles(50);
      chk("t1_count", 32'(log_w.size()), 16);
      chk("t1_addr0", 32'(log_a[0]), 0);
      chk("t1_addr1", 32'(log_a[1]), 128);
      chk("t1_addr15", 32'(log_a[15]), 1920);
      chk("t1_stopped", 32'(cmd_valid), 0);

      wr_avail = 8'd0;
      pulse_sync();
      cycles(2);
      chk("t2_buf_sel", 32'(buf_sel), 1);
      chk("t2_no_err", 32'(sync_err), 0);

      // Both eligible: four reads then a write.
      log_w.delete(); log_a.delete();
      wr_avail = 8'd20;
      rd_space = 8'd200;
      wait_hs(10, 60, "t3_timeout");
      wr_avail = 8'd0;
      rd_space = 8'd0;
      for (int i = 0; i < 10; i++) chk("t3_pattern", 32'(log_w[i]), 32'(exp_pat[i]));
      chk("t3_rd_addr0", 32'(log_a[0]), 0);
      chk("t3_wr_addr", 32'(log_a[4]), 32'(B1));
      chk("t3_rd_addr5", 32'(log_a[5]), 512);
      chk("t3_wr_addr9", 32'(log_a[9]), 32'(B1 + 27'd128));
      cycles(3);
      drain();

      // Urgent write level beats an eligible read.
      log_w.delete(); log_a.delete();
      wr_avail = 8'd48;
      rd_space = 8'd200;
      wait_hs(1, 20, "t4_timeout");
      wr_avail = 8'd0;
      rd_space = 8'd0;
      chk("t4_write_first", 32'(log_w[0]), 1);
      chk("t4_addr", 32'(log_a[0]), 32'(B1 + 27'd256));
      cycles(3);
      drain();

      // Read FIFO space limits outstanding reads.
      log_w.delete(); log_a.delete();
      rd_space = 8'd16;
      cycles(12);
      chk("t5_two_reads", 32'(log_w.size()), 2);
      chk("t5_addr0", 32'(log_a[0]), 1024);
      rd_beat_valid = 1'b1;
      cycles(7);
      rd_beat_valid = 1'b0;
      cycles(4);
      chk("t5_still_two", 32'(log_w.size()), 2);
      rd_beat_valid = 1'b1;
      cycles(1);
      rd_beat_valid = 1'b0;
      cycles(4);
      chk("t5_third_read", 32'(log_w.size()), 3);
      rd_space = 8'd0;
      drain();

      // Pause holds off commands and keeps busy high.
      enable = 1'b0;
      wr_avail = 8'd8;
      cycles(3);
      chk("pause_busy", 32'(busy), 1);
      chk("pause_no_cmd", 32'(cmd_valid), 0);
      enable = 1'b1;

      // Write up to exactly 64 words, then an early frame_sync flags an error.
      for (int i = 0; i < 200; i++) begin
         if (m_wr + ((m_mode == 1 && m_write) ? BB : 0) >= 64) break;
         @(negedge clk);
      end
      wr_avail = 8'd0;
      cycles(3);
      pulse_sync();
      cycles(1);
      chk("t7_sync_err", 32'(sync_err), 1);
      chk("t7_buf_sel", 32'(buf_sel), 0);
      cycles(5);
      chk("t7_sticky", 32'(sync_err), 1);

      // Stalled handshake with frame_sync mid-stall.
      log_w.delete(); log_a.delete();
      cmd_ready = 1'b0;
      wr_avail = 8'd8;
      for (int i = 0; i < 10 && !cmd_valid; i++) @(negedge clk);
      held = cmd_addr;
      chk("t6_held_addr", 32'(held), 0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) frame_sync = 1'b1;
         @(negedge clk);
         frame_sync = 1'b0;
         chk("t6_stable", 32'(cmd_addr), 32'(held));
      end
      cmd_ready = 1'b1;
      wait_hs(2, 10, "t6_timeout");
      wr_avail = 8'd0;
      chk("t6_first", 32'(log_a[0]), 0);
      chk("t6_next_buf1", 32'(log_a[1]), 32'(B1));
      chk("t6_buf_sel", 32'(buf_sel), 1);
      cycles(3);

      // Asynchronous reset in the middle of a write command.
      cmd_ready = 1'b0;
      wr_avail = 8'd8;
      for (int i = 0; i < 10 && !cmd_valid; i++) @(negedge clk);
      chk("t8_in_issue", 32'(cmd_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t8_cmd_valid", 32'(cmd_valid), 0);
      chk("t8_cmd_write", 32'(cmd_write), 0);
      chk("t8_cmd_addr", 32'(cmd_addr), 0);
      chk("t8_buf_sel", 32'(buf_sel), 0);
      chk("t8_busy", 32'(busy), 0);
      chk("t8_sync_err", 32'(sync_err), 0);
      wr_avail = 8'd0;
      cmd_ready = 1'b1;
      cycles(2);
      rst_n = 1'b1;
      cycles(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
